// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg: shared encodings and shadow-tag type for the hazard unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_ctrl_pkg;

  // Register-file write source encodings shared with the decoder
  localparam logic [1:0] RF_WSEL_ALU  = 2'd0;
  localparam logic [1:0] RF_WSEL_DRAM = 2'd1;

  localparam logic [1:0] FWD_SEL_RF  = 2'd0;
  localparam logic [1:0] FWD_SEL_EX  = 2'd1;
  localparam logic [1:0] FWD_SEL_MEM = 2'd2;
  localparam logic [1:0] FWD_SEL_WB  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic       is_load;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  function automatic logic tag_match(input tag_t t, input logic [4:0] r, input logic used);
    return (r != 5'd0) && used && t.valid && t.we && (t.rd == r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_tag_pipe.sv
// ---------------------------------------------------------------------------
// hazard_tag_pipe: EX/MEM/WB destination-tag shadow pipeline and perf counters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_tag_pipe
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  tag_t             id_tag,
  input  logic             bubble,
  input  logic             stall_evt,
  input  logic             flush_evt,
  output tag_t             ex_tag,
  output tag_t             mem_tag,
  output tag_t             wb_tag,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_tag  <= TAG_BUBBLE;
      mem_tag <= TAG_BUBBLE;
      wb_tag  <= TAG_BUBBLE;
    end else begin
      ex_tag  <= bubble ? TAG_BUBBLE : id_tag;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

  // Counters wrap naturally at 2^CNT_W
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl: ID-stage forwarding selects, load-use stall and branch flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit FWD_WB = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rf_we_i,
  input  logic [1:0]       id_rf_wsel_i,
  input  logic             ex_br_taken_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  tag_t id_tag;
  tag_t ex_tag;
  tag_t mem_tag;
  tag_t wb_tag;
  logic load_use;
  logic rs1_ex_hit;
  logic rs2_ex_hit;

  assign id_tag = '{valid:   id_valid_i,
                    we:      id_rf_we_i,
                    rd:      id_rd_i,
                    is_load: (id_rf_wsel_i == RF_WSEL_DRAM)};

  function automatic logic [1:0] fwd_sel(input logic valid, input logic [4:0] r,
                                         input logic used, input tag_t ex,
                                         input tag_t mem, input tag_t wb);
    if (!valid)                          return FWD_SEL_RF;
    if (tag_match(ex, r, used))          return FWD_SEL_EX;
    if (tag_match(mem, r, used))         return FWD_SEL_MEM;
    if (FWD_WB && tag_match(wb, r, used)) return FWD_SEL_WB;
    return FWD_SEL_RF;
  endfunction

  assign rs1_ex_hit = tag_match(ex_tag, id_rs1_i, id_rs1_used_i);
  assign rs2_ex_hit = tag_match(ex_tag, id_rs2_i, id_rs2_used_i);
  assign load_use   = id_valid_i && ex_tag.is_load && (rs1_ex_hit || rs2_ex_hit);

  always_comb begin
    fwd_rs1_sel_o = fwd_sel(id_valid_i, id_rs1_i, id_rs1_used_i, ex_tag, mem_tag, wb_tag);
    fwd_rs2_sel_o = fwd_sel(id_valid_i, id_rs2_i, id_rs2_used_i, ex_tag, mem_tag, wb_tag);
  end

  // A taken branch squashes ID anyway, so it overrides the load-use hold
  always_comb begin
    pc_stall_o   = load_use && !ex_br_taken_i;
    ifid_stall_o = load_use && !ex_br_taken_i;
    ifid_flush_o = ex_br_taken_i;
    idex_flush_o = ex_br_taken_i || load_use;
  end

  hazard_tag_pipe #(
    .CNT_W (CNT_W)
  ) u_tag_pipe (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .id_tag    (id_tag),
    .bubble    (idex_flush_o),
    .stall_evt (load_use && !ex_br_taken_i),
    .flush_evt (ex_br_taken_i),
    .ex_tag    (ex_tag),
    .mem_tag   (mem_tag),
    .wb_tag    (wb_tag),
    .stall_cnt (stall_cnt_o),
    .flush_cnt (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (FWD_WB=1 and FWD_WB=0)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rf_we;
  logic [1:0]  id_rf_wsel;
  logic        ex_br_taken;

  logic        pc_stall_a, ifid_stall_a, ifid_flush_a, idex_flush_a;
  logic [1:0]  fwd1_a, fwd2_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic        pc_stall_b, ifid_stall_b, ifid_flush_b, idex_flush_b;
  logic [1:0]  fwd1_b, fwd2_b;
  logic [31:0] stall_cnt_b, flush_cnt_b;

  int total = 0;
  int bad   = 0;
  logic [7:0] expq[$];

  hazard_ctrl #(.FWD_WB(1'b1), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_rf_we_i(id_rf_we), .id_rf_wsel_i(id_rf_wsel),
    .ex_br_taken_i(ex_br_taken),
    .pc_stall_o(pc_stall_a), .ifid_stall_o(ifid_stall_a),
    .ifid_flush_o(ifid_flush_a), .idex_flush_o(idex_flush_a),
    .fwd_rs1_sel_o(fwd1_a), .fwd_rs2_sel_o(fwd2_a),
    .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
  );

  hazard_ctrl #(.FWD_WB(1'b0), .CNT_W(32)) dut_nowb (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_rf_we_i(id_rf_we), .id_rf_wsel_i(id_rf_wsel),
    .ex_br_taken_i(ex_br_taken),
    .pc_stall_o(pc_stall_b), .ifid_stall_o(ifid_stall_b),
    .ifid_flush_o(ifid_flush_b), .idex_flush_o(idex_flush_b),
    .fwd_rs1_sel_o(fwd1_b), .fwd_rs2_sel_o(fwd2_b),
    .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {pc_stall, ifid_stall, ifid_flush, idex_flush, fwd1[1:0], fwd2[1:0]}
  task automatic step(input string name, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                      input logic ld, input logic br, input logic [7:0] exp);
    logic [7:0] e;
    logic [7:0] e0;
    logic [7:0] got_a;
    logic [7:0] got_b;
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rf_we    = we;
    id_rf_wsel  = ld ? RF_WSEL_DRAM : RF_WSEL_ALU;
    ex_br_taken = br;
    expq.push_back(exp);
    #1;
    e  = expq.pop_front();
    e0 = e;
    if (e0[3:2] == FWD_SEL_WB) e0[3:2] = FWD_SEL_RF;
    if (e0[1:0] == FWD_SEL_WB) e0[1:0] = FWD_SEL_RF;
    got_a = {pc_stall_a, ifid_stall_a, ifid_flush_a, idex_flush_a, fwd1_a, fwd2_a};
    got_b = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_flush_b, fwd1_b, fwd2_b};
    total++;
    if (got_a !== e) begin
      bad++;
      $display("FAIL %s (fwd_wb=1): got %b required %b", name, got_a, e);
    end
    total++;
    if (got_b !== e0) begin
      bad++;
      $display("FAIL %s (fwd_wb=0): got %b required %b", name, got_b, e0);
    end
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++)
      step("nop", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'b0000_00_00);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({stall_cnt_a, flush_cnt_a} !== 64'd0) begin
      bad++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cnt_a, flush_cnt_a);
    end
    @(negedge clk);
    step("reset_read_x5", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    rst_n = 1'b1;
    step("after_release", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
  endtask

  task automatic test_back_to_back();
    nops(3);
    step("addi_x5",     1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("add_x6_x5x5", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 8'b0000_01_01);
  endtask

  task automatic test_distance();
    nops(3);
    step("addi_x7_d2", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("filler_d2",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 8'b0000_00_00);
    step("read_x7_d2", 1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 8'b0000_10_00);
    nops(3);
    step("addi_x7_d3", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("filler_d3a", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 8'b0000_00_00);
    step("filler_d3b", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 8'b0000_00_00);
    step("read_x7_d3", 1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 8'b0000_11_00);
    nops(3);
    step("addi_x7_p1", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("addi_x7_p2", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("prio_ex",    1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 8'b0000_00_01);
    step("prio_mem",   1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 8'b0000_00_10);
  endtask

  task automatic test_load_use();
    nops(3);
    step("lw_x8_a",     1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 8'b0000_00_00);
    step("lu_rs1",      1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b1101_01_00);
    step("lu_rs1_hold", 1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b0000_10_00);
    total++;
    if ({stall_cnt_a, flush_cnt_a} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL stall_cnt_one: got %0d/%0d required 1/0", stall_cnt_a, flush_cnt_a);
    end
    nops(3);
    step("lw_x8_b",     1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 8'b0000_00_00);
    step("lu_rs2",      1'b1, 5'd0, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b1101_00_01);
    step("lu_rs2_hold", 1'b1, 5'd0, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b0000_00_10);
    nops(3);
    step("lw_x8_c",     1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 8'b0000_00_00);
    step("lu_unused",   1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    total++;
    if ({stall_cnt_a, flush_cnt_a} !== {32'd2, 32'd0}) begin
      bad++;
      $display("FAIL stall_cnt_two: got %0d/%0d required 2/0", stall_cnt_a, flush_cnt_a);
    end
  endtask

  task automatic test_x0();
    nops(3);
    step("addi_x0",    1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("add_x1_x0",  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("lw_x0",      1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'b0000_00_00);
    step("read_x0_ld", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
  endtask

  task automatic test_flush();
    nops(3);
    step("lw_x8_f",   1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 8'b0000_00_00);
    step("lu_and_br", 1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 8'b0011_01_00);
    step("post_br",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'b0000_00_00);
    total++;
    if ({stall_cnt_a, flush_cnt_a} !== {32'd2, 32'd1}) begin
      bad++;
      $display("FAIL flush_cnt_one: got %0d/%0d required 2/1", stall_cnt_a, flush_cnt_a);
    end
    step("plain_br",  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'b0011_00_00);
    total++;
    if ({stall_cnt_a, flush_cnt_a} !== {32'd2, 32'd2}) begin
      bad++;
      $display("FAIL flush_cnt_two: got %0d/%0d required 2/2", stall_cnt_a, flush_cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    nops(3);
    step("lw_x8_r", 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 8'b0000_00_00);
    rst_n = 1'b0;
    #1;
    total++;
    if ({stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b} !== 128'd0) begin
      bad++;
      $display("FAIL mid_reset_counters: got %0d/%0d and %0d/%0d required all 0",
               stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b);
    end
    #1;
    rst_n = 1'b1;
    step("read_x8_after_rst", 1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
    step("read_x8_again",     1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b0000_00_00);
  endtask

  initial begin
    rst_n       = 1'b0;
    id_valid    = 1'b0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd       = 5'd0;
    id_rf_we    = 1'b0;
    id_rf_wsel  = RF_WSEL_ALU;
    ex_br_taken = 1'b0;
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
